// File: rtl/adder_core.sv
// adder_core: registered N-bit two-operand adder built on a block
// carry-lookahead structure, used as a switching-activity and energy
// characterization target.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input1/input2 are valid this cycle
//   input1     operand A, N bits
//   input2     operand B, N bits
//   sum        registered (input1 + input2) mod 2^N
//   carry_out  registered carry out of bit N-1
//   overflow   registered two's-complement overflow
//   out_valid  outputs hold a new result this cycle
//   toggle_count (only with ADDER_TOGGLE_CNT_EN) saturating count of operand
//              bit toggles between successive accepted operand pairs
//
// Optional feature macro: ADDER_TOGGLE_CNT_EN
module adder_core #(
    parameter int N   = 27,
    parameter int BLK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow,
`ifdef ADDER_TOGGLE_CNT_EN
    output logic [31:0]  toggle_count,
`endif
    output logic         out_valid
);

    localparam int NGRP = (N + BLK - 1) / BLK;

    logic [N-1:0] g, p;
    logic [N:0]   c;
    logic [N-1:0] s_comb;
    logic         gg, pp;

    assign g = input1 & input2;
    assign p = input1 ^ input2;

    // Each bit's carry is formed from the group-local generate/propagate
    // prefix and the group's incoming carry; the carry into the next group
    // is the group generate/propagate applied to that same incoming carry.
    always_comb begin
        c  = '0;
        gg = 1'b0;
        pp = 1'b1;
        for (int gi = 0; gi < NGRP; gi++) begin
            for (int j = 0; j < BLK; j++) begin
                if (gi * BLK + j < N) begin
                    gg = 1'b0;
                    pp = 1'b1;
                    for (int k = 0; k <= j; k++) begin
                        gg = g[gi*BLK+k] | (p[gi*BLK+k] & gg);
                        pp = pp & p[gi*BLK+k];
                    end
                    c[gi*BLK+j+1] = gg | (pp & c[gi*BLK]);
                end
            end
        end
    end

    assign s_comb = p ^ c[N-1:0];

    logic [N-1:0] sum_d, sum_q;
    logic         carry_d, carry_q;
    logic         ovf_d, ovf_q;
    logic         vld_d, vld_q;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        vld_d   = in_valid;
        if (in_valid) begin
            sum_d   = s_comb;
            carry_d = c[N];
            ovf_d   = (input1[N-1] == input2[N-1]) && (s_comb[N-1] != input1[N-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;

`ifdef ADDER_TOGGLE_CNT_EN
    localparam int PCW = $clog2(2 * N + 1);

    logic [2*N-1:0] prev_ops_d, prev_ops_q;
    logic [2*N-1:0] ops_diff;
    logic [PCW-1:0] pc;
    logic [32:0]    cnt_sum;
    logic [31:0]    toggle_cnt_d, toggle_cnt_q;

    assign ops_diff = {input2, input1} ^ prev_ops_q;

    always_comb begin
        pc = '0;
        for (int i = 0; i < 2 * N; i++) begin
            pc = pc + PCW'(ops_diff[i]);
        end
    end

    // 33-bit add so the saturation test is just the top bit.
    assign cnt_sum = {1'b0, toggle_cnt_q} + 33'(pc);

    always_comb begin
        prev_ops_d   = prev_ops_q;
        toggle_cnt_d = toggle_cnt_q;
        if (in_valid) begin
            prev_ops_d   = {input2, input1};
            toggle_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ops_q   <= '0;
            toggle_cnt_q <= '0;
        end else begin
            prev_ops_q   <= prev_ops_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign toggle_count = toggle_cnt_q;
`endif

endmodule

// File: tb/tb_adder_core.sv
module tb_adder_core;

    localparam int N = 27;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] input1, input2;
    logic [N-1:0] sum;
    logic         carry_out, overflow, out_valid;
`ifdef ADDER_TOGGLE_CNT_EN
    logic [31:0]  toggle_count;
`endif

    int nvec = 0;
    int nmis = 0;

    adder_core #(.N(N), .BLK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .input1    (input1),
        .input2    (input2),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
`ifdef ADDER_TOGGLE_CNT_EN
        .toggle_count (toggle_count),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid = v;
        input1   = a;
        input2   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 27'h7FFFFFF, 27'h7FFFFFF);
            nvec++;
            if ({sum, carry_out, overflow, out_valid} !== {27'h0, 3'b000}) begin
                nmis++;
                $display("FAIL reset[%0d] got sum=%h c=%b o=%b v=%b want 0/0/0/0",
                         i, sum, carry_out, overflow, out_valid);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        cyc(1'b1, 27'h00003FF, 27'h0000000);
        nvec++;
        if ({sum, carry_out, overflow, out_valid} !== {27'h00003FF, 3'b001}) begin
            nmis++;
            $display("FAIL basic got sum=%h c=%b o=%b v=%b want 00003ff/0/0/1",
                     sum, carry_out, overflow, out_valid);
        end
    endtask

    task automatic test_carry;
        cyc(1'b1, 27'h7FFFFE0, 27'h7FFFFFF);
        nvec++;
        if ({sum, carry_out, overflow, out_valid} !== {27'h7FFFFDF, 3'b101}) begin
            nmis++;
            $display("FAIL carry1 got sum=%h c=%b o=%b v=%b want 7ffffdf/1/0/1",
                     sum, carry_out, overflow, out_valid);
        end
        cyc(1'b1, 27'h7FFFFFF, 27'h7FFFFFF);
        nvec++;
        if ({sum, carry_out, overflow, out_valid} !== {27'h7FFFFFE, 3'b101}) begin
            nmis++;
            $display("FAIL carry2 got sum=%h c=%b o=%b v=%b want 7fffffe/1/0/1",
                     sum, carry_out, overflow, out_valid);
        end
    endtask

    task automatic test_overflow;
        cyc(1'b1, 27'h3FFFFFF, 27'h0000001);
        nvec++;
        if ({sum, carry_out, overflow, out_valid} !== {27'h4000000, 3'b011}) begin
            nmis++;
            $display("FAIL ovf got sum=%h c=%b o=%b v=%b want 4000000/0/1/1",
                     sum, carry_out, overflow, out_valid);
        end
        cyc(1'b1, 27'h7FFFFFF, 27'h0000001);
        nvec++;
        if ({sum, carry_out, overflow, out_valid} !== {27'h0000000, 3'b101}) begin
            nmis++;
            $display("FAIL wrap got sum=%h c=%b o=%b v=%b want 0000000/1/0/1",
                     sum, carry_out, overflow, out_valid);
        end
        // Negative + negative overflowing into positive.
        cyc(1'b1, 27'h4000000, 27'h4000000);
        nvec++;
        if ({sum, carry_out, overflow, out_valid} !== {27'h0000000, 3'b111}) begin
            nmis++;
            $display("FAIL negovf got sum=%h c=%b o=%b v=%b want 0000000/1/1/1",
                     sum, carry_out, overflow, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] a, b;
        logic [N:0]   full;
        logic [N-1:0] e_sum;
        logic         e_c, e_o;
        e_sum = 27'h0; e_c = 1'b1; e_o = 1'b1; // from last negovf vector
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 20; i++) begin
                a = N'($urandom);
                b = N'($urandom);
                if (i == 3) begin a = 27'h7FFFFFF; b = N'(r + 1); end
                if (r == 5 && i == 10) begin
                    rst = 1'b1;
                    cyc(1'b1, a, b);
                    rst = 1'b0;
                    e_sum = '0; e_c = 1'b0; e_o = 1'b0;
                    nvec++;
                    if ({sum, carry_out, overflow, out_valid} !== {27'h0, 3'b000}) begin
                        nmis++;
                        $display("FAIL midrst got sum=%h c=%b o=%b v=%b want 0/0/0/0",
                                 sum, carry_out, overflow, out_valid);
                    end
                end else begin
                    cyc(1'b1, a, b);
                    full  = {1'b0, a} + {1'b0, b};
                    e_sum = full[N-1:0];
                    e_c   = full[N];
                    e_o   = (a[N-1] == b[N-1]) && (e_sum[N-1] != a[N-1]);
                    nvec++;
                    if ({sum, carry_out, overflow, out_valid} !== {e_sum, e_c, e_o, 1'b1}) begin
                        nmis++;
                        $display("FAIL b2b[%0d.%0d] %h+%h got %h/%b/%b/%b want %h/%b/%b/1",
                                 r, i, a, b, sum, carry_out, overflow, out_valid, e_sum, e_c, e_o);
                    end
                end
            end
            for (int i = 0; i < 7; i++) begin
                cyc(1'b0, N'($urandom), N'($urandom));
                nvec++;
                if ({sum, carry_out, overflow, out_valid} !== {e_sum, e_c, e_o, 1'b0}) begin
                    nmis++;
                    $display("FAIL idle[%0d.%0d] got %h/%b/%b/%b want %h/%b/%b/0",
                             r, i, sum, carry_out, overflow, out_valid, e_sum, e_c, e_o);
                end
            end
        end
    endtask

`ifdef ADDER_TOGGLE_CNT_EN
    task automatic test_toggle;
        rst = 1'b1;
        cyc(1'b0, 27'h0, 27'h0);
        rst = 1'b0;
        cyc(1'b1, 27'h0, 27'h0);
        nvec++;
        if (toggle_count !== 32'd0) begin
            nmis++;
            $display("FAIL tog0 got %0d want 0", toggle_count);
        end
        cyc(1'b1, 27'h00003FF, 27'h0);
        nvec++;
        if (toggle_count !== 32'd10) begin
            nmis++;
            $display("FAIL tog1 got %0d want 10", toggle_count);
        end
        cyc(1'b1, 27'h7FFFFE0, 27'h7FFFFFF);
        nvec++;
        if (toggle_count !== 32'd59) begin
            nmis++;
            $display("FAIL tog2 got %0d want 59", toggle_count);
        end
        cyc(1'b0, 27'h0, 27'h0);
        nvec++;
        if (toggle_count !== 32'd59) begin
            nmis++;
            $display("FAIL toghold got %0d want 59", toggle_count);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        input1   = '0;
        input2   = '0;
        test_reset;
        test_basic;
        test_carry;
        test_overflow;
        test_back_to_back;
`ifdef ADDER_TOGGLE_CNT_EN
        test_toggle;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/adder_core.md
Name: adder_core

Overview:
- Registered N-bit two-operand binary adder used as the characterization target for switching-activity and energy estimation.
- Operands are sampled on each valid cycle and the modulo-2^N sum, carry and signed-overflow flags are presented one clock later.
- The datapath is a parameterized block carry-lookahead structure, so activity numbers reflect a realistic adder rather than a bare "+" operator.

Parameters:
- N, 27: operand and sum width in bits; legal range is 2 or more.
- BLK, 4: carry-lookahead group width in bits. N need not be a multiple of BLK; the last group is partial.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: operands are valid this cycle.
- input1, in, N: operand A, unsigned or two's complement.
- input2, in, N: operand B.
- sum, out, N: registered (input1 + input2) mod 2^N.
- carry_out, out, 1: registered unsigned carry out of bit N-1.
- overflow, out, 1: registered two's-complement overflow.
- out_valid, out, 1: sum, carry_out and overflow hold a new result this cycle.

Behaviour:
- Reset, synchronous: when rst=1 at a clk edge, sum=0, carry_out=0, overflow=0 and out_valid=0. rst takes priority over in_valid in the same cycle.
  - A reset asserted mid-stream discards any in-flight result. The first valid result after rst is deasserted appears one cycle after the first accepted in_valid.
- Latency: exactly 1 cycle.
  - When in_valid=1 at edge k, sum, carry_out and overflow update at edge k and out_valid=1 until edge k+1.
  - When in_valid=0 at an edge, sum, carry_out and overflow hold their previous values and out_valid=0.
  - There is no backpressure: a new operand pair is accepted every cycle, throughput 1 per cycle.
- Arithmetic:
  - Carry-in is fixed at 0.
  - Per bit: g_i = a_i & b_i and p_i = a_i ^ b_i.
  - Within each BLK group, carries are computed by lookahead. Group generate/propagate values chain the group carries.
  - sum_i = p_i ^ c_i.
  - carry_out = c_N, the full (N+1)-bit sum MSB.
  - overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]).
- Wrap-around: results wrap modulo 2^N and there is no saturation.
  - Example: all-ones + 1 gives sum=0, carry_out=1, overflow=0.
- Operands are combinational into the lookahead logic. Only the outputs (and the optional counter) are registered; there are no input registers.
- X/Z on operands while in_valid=0 must not affect outputs.

Optional Feature:
- Macro: ADDER_TOGGLE_CNT_EN.
- When defined:
  - Adds output toggle_count, 32 bits, and an internal register prev_ops of 2N bits.
  - On each accepted in_valid cycle, toggle_count increments by popcount({input2,input1} ^ prev_ops), and prev_ops is loaded with {input2,input1}.
  - The counter saturates at 2^32-1.
  - rst clears toggle_count and prev_ops to 0.
  - Gives an on-chip switching-activity estimate that can be compared with the VCD-based energy flow.
- When not defined:
  - The port, register and popcount logic are absent.
  - The remaining behaviour is identical.

Test Plan (N=27, BLK=4):
- Reset: hold rst=1 with in_valid=1 and operands 0x7FFFFFF/0x7FFFFFF for 2 cycles -> sum=0, carry_out=0, overflow=0, out_valid=0.
- Basic add: input1=0x00003FF, input2=0x0000000, in_valid=1 -> next cycle sum=0x00003FF, carry_out=0, overflow=0, out_valid=1.
- Carry out:
  - input1=0x7FFFFE0, input2=0x7FFFFFF -> sum=0x7FFFFDF, carry_out=1, overflow=0.
  - input1=input2=0x7FFFFFF -> sum=0x7FFFFFE, carry_out=1.
- Signed overflow and wrap:
  - input1=0x3FFFFFF, input2=0x0000001 -> sum=0x4000000, overflow=1, carry_out=0.
  - input1=0x7FFFFFF, input2=0x0000001 -> sum=0, carry_out=1, overflow=0.
- Valid gating / back-to-back:
  - Apply 20 consecutive valid operand pairs, then 7 idle cycles, repeated 10 times -> each result matches a reference model exactly one cycle later.
  - Outputs hold during idle cycles with out_valid=0.
  - Asserting rst in the middle of a burst clears out_valid on the next edge.
- Toggle counter (ADDER_TOGGLE_CNT_EN defined): after reset, send 0/0, then 0x00003FF/0, then 0x7FFFFE0/0x7FFFFFF -> toggle_count = 0, then 10, then 10 + popcount(0x7FFFC1F) + 27 = 10 + 22 + 27 = 59.
